// File: rtl/alu_seq_unit.sv
// Registered ALU execution stage with a start/busy/done handshake.
// Logic ops, ADD/SUB and SLT finish in one cycle; SLL shifts one bit per clock.
module alu_seq_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALU_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             OF,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   a_q, b_q, work_q;
  logic [2:0]         op_q;
  logic [SHAMT_W-1:0] cnt_q;

  logic [WIDTH-1:0]   a_d, b_d, work_d, f_d;
  logic [2:0]         op_d;
  logic [SHAMT_W-1:0] cnt_d;
  logic               zf_d, of_d, done_d, busy_d;

  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_of;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (ALU_OP == OP_SLL) ? SHIFT : EXEC;
      EXEC:    state_nxt = IDLE;
      SHIFT:   if (cnt_q == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  // Single-cycle ALU on the latched operands; SLT uses a true signed compare so
  // it stays correct when A-B overflows.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOR: alu_res = ~(a_q | b_q);
      OP_ADD: begin
        alu_res = sum;
        alu_of  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_of  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT: alu_res = WIDTH'(($signed(a_q) < $signed(b_q)) ? 1 : 0);
      OP_SLL: alu_res = b_q << a_q[SHAMT_W-1:0];
      default: alu_res = '0;
    endcase
  end

  // Output / datapath next values; results and flags hold unless completing
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    work_d = work_q;
    f_d    = F;
    zf_d   = ZF;
    of_d   = OF;
    done_d = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          a_d    = A;
          b_d    = B;
          op_d   = ALU_OP;
          cnt_d  = A[SHAMT_W-1:0];
          work_d = B;
        end
      end
      EXEC: begin
        f_d    = alu_res;
        zf_d   = (alu_res == '0);
        of_d   = alu_of;
        done_d = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          f_d    = work_q;
          zf_d   = (work_q == '0);
          of_d   = 1'b0;
          done_d = 1'b1;
        end else begin
          work_d = work_q << 1;
          cnt_d  = cnt_q - SHAMT_W'(1);
        end
      end
      default: ;
    endcase
    busy_d = (state_nxt != IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt_q  <= '0;
      work_q <= '0;
      F      <= '0;
      ZF     <= 1'b0;
      OF     <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      work_q <= work_d;
      F      <= f_d;
      ZF     <= zf_d;
      OF     <= of_d;
      done   <= done_d;
      busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed testbench for alu_seq_unit: hand-computed results, flags, latency
// and handshake behaviour including reset abort and back-to-back starts.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b1;
  logic [2:0]  ALU_OP = 3'b100;
  logic [31:0] A = 32'h0000_0007;
  logic [31:0] B = 32'h0000_0009;
  logic [31:0] F;
  logic        ZF, OF, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ALU_OP (ALU_OP),
    .A      (A),
    .B      (B),
    .F      (F),
    .ZF     (ZF),
    .OF     (OF),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present an op and hold start across one rising edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    A      = a;
    B      = b;
    ALU_OP = op;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Returns at the negedge where done is high; k counts edges after accept.
  task automatic wait_done(input string tag, input int elat, input bit disturb);
    int k;
    int nbusy;
    k = 0;
    nbusy = 0;
    while (done !== 1'b1 && k < 64) begin
      if (busy === 1'b1) nbusy++;
      if (disturb && k == 1) begin
        A = 32'hDEAD_BEEF;
        B = 32'h1234_5678;
        ALU_OP = 3'b000;
        start = 1'b1;
      end
      if (disturb && k == 2) start = 1'b0;
      @(negedge clk);
      k++;
    end
    check($sformatf("%s_lat", tag), 32'(k), 32'(elat));
    check($sformatf("%s_busycnt", tag), 32'(nbusy), 32'(elat));
    check($sformatf("%s_busy_in_done", tag), {31'b0, busy}, 32'd0);
  endtask

  task automatic check_res(input string tag, input logic [31:0] ef, input logic ezf, input logic eof);
    check($sformatf("%s_F", tag), F, ef);
    check($sformatf("%s_ZF", tag), {31'b0, ZF}, {31'b0, ezf});
    check($sformatf("%s_OF", tag), {31'b0, OF}, {31'b0, eof});
  endtask

  // One cycle after done: pulse gone, idle, result held.
  task automatic finish_op(input string tag, input logic [31:0] ef);
    @(negedge clk);
    check($sformatf("%s_done_pulse", tag), {31'b0, done}, 32'd0);
    check($sformatf("%s_idle", tag), {31'b0, busy}, 32'd0);
    check($sformatf("%s_hold", tag), F, ef);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] ef, input logic ezf,
                        input logic eof, input int elat);
    launch(a, b, op);
    wait_done(tag, elat, 1'b0);
    check_res(tag, ef, ezf, eof);
    finish_op(tag, ef);
  endtask

  initial begin
    int seen;

    // Reset held for two edges with start asserted
    @(negedge clk);
    @(negedge clk);
    check("rst_F", F, 32'd0);
    check("rst_ZF", {31'b0, ZF}, 32'd0);
    check("rst_OF", {31'b0, OF}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_no_accept", {31'b0, busy}, 32'd0);

    run_op("add_ovf",  32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'b100, 32'hFFFF_FFFE, 1'b0, 1'b1, 1);
    run_op("add_zero", 32'h8000_0000, 32'h8000_0000, 3'b100, 32'h0000_0000, 1'b1, 1'b1, 1);
    run_op("sub",      32'h8000_0000, 32'hFFFF_FFFF, 3'b101, 32'h8000_0001, 1'b0, 1'b0, 1);
    run_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 3'b101, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
    run_op("slt",      32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 32'h0000_0001, 1'b0, 1'b0, 1);
    run_op("slt_no",   32'h7FFF_FFFF, 32'h8000_0000, 3'b110, 32'h0000_0000, 1'b1, 1'b0, 1);
    run_op("and",      32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b000, 32'h0000_0000, 1'b1, 1'b0, 1);
    run_op("or",       32'h1234_0000, 32'h0000_5678, 3'b001, 32'h1234_5678, 1'b0, 1'b0, 1);
    run_op("nor",      32'h0000_0000, 32'h0000_0000, 3'b011, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    run_op("sll0",     32'h0000_0020, 32'h0000_ABCD, 3'b111, 32'h0000_ABCD, 1'b0, 1'b0, 1);

    // SLL by 3 with inputs disturbed and a second start while busy
    launch(32'h0000_0003, 32'h0000_0607, 3'b111);
    wait_done("sll3", 4, 1'b1);
    check_res("sll3", 32'h0000_3038, 1'b0, 1'b0);
    // Back-to-back: start presented in the done cycle
    launch(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010);
    wait_done("xor_b2b", 1, 1'b0);
    check_res("xor_b2b", 32'h0FF0_0FF0, 1'b0, 1'b0);
    finish_op("xor_b2b", 32'h0FF0_0FF0);

    // Reset on the 5th busy cycle of a 31-bit shift
    launch(32'h0000_001F, 32'h0000_0001, 3'b111);
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("abort_busy_pre", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_F", F, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_op("post_abort", 32'h0000_0001, 32'h0000_0002, 3'b100, 32'h0000_0003, 1'b0, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
